// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MDU_FAST_MULT_EN for single-cycle MULT/MULTU; divides stay iterative.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic             div_take;
  logic [WIDTH-1:0] div_diff;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo, rem;
`ifdef MDU_FAST_MULT_EN
  logic [W2-1:0]    fast_a, fast_b, fast_prod;
`endif

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    // acc holds {partial product, remaining multiplier} or {remainder, quotient}
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? dvs_q : {WIDTH{1'b0}})};
    div_take  = acc_q[W2-1:WIDTH-1] >= {1'b0, dvs_q};
    div_diff  = acc_q[W2-2:WIDTH-1] - dvs_q;
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo       = acc_q[WIDTH-1:0];
    rem       = acc_q[W2-1:WIDTH];
`ifdef MDU_FAST_MULT_EN
    fast_a    = signed_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    fast_b    = signed_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    fast_prod = fast_a * fast_b;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
`ifdef MDU_FAST_MULT_EN
            if (!op[1]) begin
              hi_d    = fast_prod[W2-1:WIDTH];
              lo_d    = fast_prod[WIDTH-1:0];
              state_d = S_DONE;
            end else begin
`else
            begin
`endif
              is_div_d  = op[1];
              neg_d     = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              div0_d    = (b == '0);
              dvs_d     = op[1] ? b_mag : a_mag;
              acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
              cnt_d     = '0;
              state_d   = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (is_div_q) begin
            acc_d = div_take ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                             : {acc_q[W2-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) state_d = S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            // Divide by zero leaves quotient all-ones; remainder re-signs back to a
            hi_d = neg_rem_q ? -rem : rem;
            lo_d = (neg_q && !div0_q) ? -quo : quo;
          end else begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      dvs_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and random checks for mdu_iter: results, latency, busy/done, flush and reset.
module tb_mdu_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] exp_q[$];
  int          total;
  int          passed;

  mdu_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int lat_of(input logic [1:0] o);
`ifdef MDU_FAST_MULT_EN
    return o[1] ? 34 : 1;
`else
    return 34;
`endif
  endfunction

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic signed [31:0] dx, dy, q, r;
    case (o)
      2'b00: begin
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
      end
      2'b01: return {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        dx = $signed(x);
        dy = $signed(y);
        q  = dx / dy;
        r  = dx % dy;
        return {r, q};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // driver: holds start for one cycle; returns in cycle 1 of the operation
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] expv, input bit push);
    if (push) exp_q.push_back(expv);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // waits for done, checking latency, busy profile and the scoreboard result
  task automatic wait_done(input string tag, input int exp_lat, input bit hold);
    int          k;
    bit          got;
    int          busy_err;
    logic [63:0] expv;
    k        = 1;
    got      = 1'b0;
    busy_err = 0;
    if (hold) begin
      op = 2'b01;
      a  = 32'd3;
      b  = 32'd3;
    end
    while (!got && k <= 60) begin
      start = hold && (k <= 33);
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (busy !== (exp_lat > 1)) busy_err++;
        step();
        k++;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, 64'(got), 64'd1);
    check({tag, " busy_profile_errs"}, 64'(busy_err), 64'd0);
    if (got) begin
      check({tag, " latency"}, 64'(k), 64'(exp_lat));
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      expv = exp_q.pop_front();
      check({tag, " result"}, {hi, lo}, expv);
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] expv);
    start_op(o, x, y, expv, 1'b1);
    wait_done(tag, lat_of(o), 1'b0);
  endtask

  initial begin
    logic [63:0] prev;
    int          dcnt;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    total  = 0;
    passed = 0;
    reset  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    repeat (3) step();
    reset = 1'b1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    step();

    // directed results; each start is issued in the previous done cycle
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    run_op("divu_plain", 2'b11, 32'd1000, 32'd7, {32'd6, 32'd142});

    // start held high while busy must not restart the divide
    start_op(2'b11, 32'd50, 32'd7, {32'd1, 32'd7}, 1'b1);
    wait_done("start_while_busy", 34, 1'b1);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i == 0) ry = $urandom_range(1, 20);
      run_op($sformatf("rand%0d", i), ro, rx, ry, model(ro, rx, ry));
    end

    // flush in cycle 10 aborts with no done and hi/lo held
    step();
    prev = {hi, lo};
    start_op(2'b11, 32'd50, 32'd7, 64'd0, 1'b0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush hilo_held", {hi, lo}, prev);
    dcnt = 0;
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0) dcnt++;
      step();
    end
    check("flush no_done", 64'(dcnt), 64'd0);

    // flush beats start in the same cycle
    op    = 2'b11;
    a     = 32'd9;
    b     = 32'd2;
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    check("flush_vs_start busy", 64'(busy), 64'd0);

    // reset in cycle 5 discards the operation
    run_op("before_reset", 2'b01, 32'd6, 32'd7, {32'd0, 32'd42});
    step();
    start_op(2'b11, 32'd50, 32'd7, 64'd0, 1'b0);
    repeat (4) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset hilo", {hi, lo}, 64'd0);
    dcnt = 0;
    repeat (40) begin
      if (done !== 1'b0) dcnt++;
      step();
    end
    check("midreset no_done", 64'(dcnt), 64'd0);

    run_op("after_reset", 2'b10, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
    check("scoreboard empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
